// File: rtl/wb_bus_decoder_n_if.sv
// Bundle of master-side and slave-side Wishbone signals around the bus decoder.
// The slave modport is the decoder's own view; the master modport is the surrounding SoC's view.
interface wb_bus_decoder_n_if #(
    parameter int NUM_SLAVES = 5,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    logic [ADDR_W-1:0]            m_adr_i;
    logic [DATA_W-1:0]            m_dat_i;
    logic [DATA_W/8-1:0]          m_sel_i;
    logic                         m_we_i;
    logic                         m_cyc_i;
    logic                         m_stb_i;
    logic [DATA_W-1:0]            m_dat_o;
    logic                         m_ack_o;
    logic                         m_err_o;
    logic [ADDR_W-1:0]            s_adr_o;
    logic [DATA_W-1:0]            s_dat_o;
    logic [DATA_W/8-1:0]          s_sel_o;
    logic                         s_we_o;
    logic [NUM_SLAVES-1:0]        s_cyc_o;
    logic [NUM_SLAVES-1:0]        s_stb_o;
    logic [NUM_SLAVES*DATA_W-1:0] s_dat_i;
    logic [NUM_SLAVES-1:0]        s_ack_i;
    logic [NUM_SLAVES-1:0]        s_err_i;
    logic                         timeout_o;
    logic [ADDR_W-1:0]            err_addr_o;

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output timeout_o, err_addr_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        output s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        input  timeout_o, err_addr_o
    );
endinterface

// File: rtl/wb_bus_decoder_n.sv
// 1-master/N-slave Wishbone classic decoder with base/mask slave selection,
// error response for unmapped addresses and a bus-timeout watchdog.
module wb_bus_decoder_n #(
    parameter int NUM_SLAVES = 5,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {32'h4000_0000, 32'h3000_0000,
                                                       32'h2000_0000, 32'h1000_0000,
                                                       32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {32'hF000_0000, 32'hF000_0000,
                                                       32'hF000_0000, 32'hF000_0000,
                                                       32'hF000_0000},
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                clk,
    input logic                reset_n,
    wb_bus_decoder_n_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, ERR_RESP} state_t;

    state_t                state_q, state_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     err_addr_q, err_addr_d;
    logic                  timeout_q, timeout_d;

    logic [NUM_SLAVES-1:0] hit_sel;
    logic                  hit_any;
    logic [DATA_W-1:0]     rd_mux;
    logic                  req;
    logic                  ack_sel;
    logic                  err_sel;
    logic [NUM_SLAVES-1:0] s_cyc;
    logic [DATA_W-1:0]     m_dat;
    logic                  m_ack;
    logic                  m_err;

    assign req     = bus.m_cyc_i & bus.m_stb_i;
    assign ack_sel = |(bus.s_ack_i & sel_q);
    assign err_sel = |(bus.s_err_i & sel_q);

    // Priority decode: the lowest-index slave whose window matches wins on overlap.
    always_comb begin
        hit_sel = '0;
        hit_any = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit_any &&
                ((bus.m_adr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
                hit_sel[i] = 1'b1;
                hit_any    = 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                rd_mux = rd_mux | bus.s_dat_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        err_addr_d = err_addr_q;
        timeout_d  = 1'b0;
        s_cyc      = '0;
        m_dat      = '0;
        m_ack      = 1'b0;
        m_err      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit_any) begin
                        sel_d   = hit_sel;
                        cnt_d   = '0;
                        state_d = ACTIVE;
                    end else begin
                        err_addr_d = bus.m_adr_i;
                        state_d    = ERR_RESP;
                    end
                end
            end
            ACTIVE: begin
                m_dat = rd_mux;
                if (!bus.m_cyc_i) begin
                    sel_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    if (req) begin
                        s_cyc = sel_q;
                    end
                    // Error outranks a simultaneous ack from the same slave.
                    if (req && err_sel) begin
                        m_err      = 1'b1;
                        err_addr_d = bus.m_adr_i;
                        sel_d      = '0;
                        state_d    = IDLE;
                    end else if (req && ack_sel) begin
                        m_ack   = 1'b1;
                        sel_d   = '0;
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_addr_d = bus.m_adr_i;
                        timeout_d  = 1'b1;
                        sel_d      = '0;
                        state_d    = ERR_RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ERR_RESP: begin
                m_err   = 1'b1;
                sel_d   = '0;
                state_d = IDLE;
            end
            default: begin
                sel_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            err_addr_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            err_addr_q <= err_addr_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.s_adr_o    = bus.m_adr_i;
    assign bus.s_dat_o    = bus.m_dat_i;
    assign bus.s_sel_o    = bus.m_sel_i;
    assign bus.s_we_o     = bus.m_we_i;
    assign bus.s_cyc_o    = s_cyc;
    assign bus.s_stb_o    = s_cyc;
    assign bus.m_dat_o    = m_dat;
    assign bus.m_ack_o    = m_ack;
    assign bus.m_err_o    = m_err;
    assign bus.timeout_o  = timeout_q;
    assign bus.err_addr_o = err_addr_q;

endmodule

// File: tb/tb_wb_bus_decoder_n.sv
// Directed bench for wb_bus_decoder_n: a table of single transfers plus hand-written
// sequences for watchdog expiry, master abort with stray ack, and reset mid-transfer.
module tb_wb_bus_decoder_n;

    localparam int NS = 5;
    localparam logic [NS*32-1:0] BASE = {32'h4000_0000, 32'h1000_0000, 32'h2000_0000,
                                         32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_0000, 32'hF000_0000,
                                         32'hF000_0000, 32'hF000_0000};

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdat;
        int          resp_slave;
        logic        resp_ack;
        logic        resp_err;
        int          delay;
        logic [31:0] rdat;
        logic [4:0]  exp_sel;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
        logic [31:0] exp_err_addr;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[7];
    vec_t extra;

    wb_bus_decoder_n_if #(.NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32)) bus ();

    wb_bus_decoder_n #(
        .NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got hang expected finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        bus.s_ack_i = '0;
        bus.s_err_i = '0;
    endtask

    task automatic start_req(input logic [31:0] adr, input logic we, input logic [31:0] wdat);
        bus.m_adr_i = adr;
        bus.m_we_i  = we;
        bus.m_dat_i = wdat;
        bus.m_sel_i = 4'hF;
        bus.m_cyc_i = 1'b1;
        bus.m_stb_i = 1'b1;
        bus.s_ack_i = '0;
        bus.s_err_i = '0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        start_req(v.adr, v.we, v.wdat);
        #1;
        check_output("no_strobe_same_cycle", 32'(bus.s_stb_o), 32'h0);
        check_output("bcast_adr", bus.s_adr_o, v.adr);
        check_output("bcast_dat", bus.s_dat_o, v.wdat);
        check_output("bcast_we", 32'(bus.s_we_o), 32'(v.we));
        tick();
        if (v.exp_sel != 5'b0) begin
            check_output("strobe_sel", 32'(bus.s_stb_o), 32'(v.exp_sel));
            check_output("cyc_sel", 32'(bus.s_cyc_o), 32'(v.exp_sel));
            check_output("no_early_ack", 32'(bus.m_ack_o), 32'h0);
            repeat (v.delay) tick();
            bus.s_dat_i[v.resp_slave*32 +: 32] = v.rdat;
            bus.s_ack_i[v.resp_slave] = v.resp_ack;
            bus.s_err_i[v.resp_slave] = v.resp_err;
            #1;
            check_output("term_ack", 32'(bus.m_ack_o), 32'(v.exp_ack));
            check_output("term_err", 32'(bus.m_err_o), 32'(v.exp_err));
            check_output("term_dat", bus.m_dat_o, v.exp_dat);
            tick();
            drop_all();
            #1;
        end else begin
            check_output("unmapped_cyc", 32'(bus.s_cyc_o), 32'h0);
            check_output("unmapped_err", 32'(bus.m_err_o), 32'(v.exp_err));
            check_output("unmapped_ack", 32'(bus.m_ack_o), 32'h0);
            check_output("unmapped_dat", bus.m_dat_o, 32'h0);
            drop_all();
            tick();
        end
        check_output("idle_ack", 32'(bus.m_ack_o), 32'h0);
        check_output("idle_err", 32'(bus.m_err_o), 32'h0);
        check_output("idle_cyc", 32'(bus.s_cyc_o), 32'h0);
        check_output("idle_dat", bus.m_dat_o, 32'h0);
        check_output("err_addr", bus.err_addr_o, v.exp_err_addr);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0010, 1'b0, 32'h0, 0, 1'b1, 1'b0, 3, 32'hDEAD_BEEF,
                    5'b00001, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{32'h7000_0000, 1'b1, 32'h1111_2222, 0, 1'b0, 1'b0, 0, 32'h0,
                    5'b00000, 1'b0, 1'b1, 32'h0, 32'h7000_0000};
        vecs[2] = '{32'h2000_0040, 1'b1, 32'hA5A5_0F0F, 2, 1'b1, 1'b0, 0, 32'h1234_5678,
                    5'b00100, 1'b1, 1'b0, 32'h1234_5678, 32'h7000_0000};
        vecs[3] = '{32'h1000_0004, 1'b0, 32'h0, 1, 1'b1, 1'b1, 1, 32'hCAFE_0001,
                    5'b00010, 1'b0, 1'b1, 32'hCAFE_0001, 32'h1000_0004};
        vecs[4] = '{32'h1001_0000, 1'b0, 32'h0, 1, 1'b1, 1'b0, 2, 32'h0BAD_F00D,
                    5'b00010, 1'b1, 1'b0, 32'h0BAD_F00D, 32'h1000_0004};
        vecs[5] = '{32'h4000_0FFC, 1'b0, 32'h0, 4, 1'b0, 1'b1, 1, 32'h55AA_55AA,
                    5'b10000, 1'b0, 1'b1, 32'h55AA_55AA, 32'h4000_0FFC};
        vecs[6] = '{32'h4000_1000, 1'b0, 32'h0, 0, 1'b0, 1'b0, 0, 32'h0,
                    5'b00000, 1'b0, 1'b1, 32'h0, 32'h4000_1000};

        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.m_we_i  = 1'b0;
        bus.s_dat_i = '0;
        drop_all();
        repeat (2) tick();
        check_output("reset_cyc", 32'(bus.s_cyc_o), 32'h0);
        check_output("reset_ack", 32'(bus.m_ack_o), 32'h0);
        check_output("reset_err", 32'(bus.m_err_o), 32'h0);
        check_output("reset_timeout", 32'(bus.timeout_o), 32'h0);
        check_output("reset_err_addr", bus.err_addr_o, 32'h0);
        check_output("reset_dat", bus.m_dat_o, 32'h0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Slave 2 never answers: eight strobed cycles, then timeout and error together.
        bus.s_dat_i = '0;
        start_req(32'h2000_0100, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check_output("wd_strobe", 32'(bus.s_stb_o), 32'h4);
            check_output("wd_no_early_timeout", 32'(bus.timeout_o), 32'h0);
            if (i < 7) tick();
        end
        tick();
        check_output("wd_timeout", 32'(bus.timeout_o), 32'h1);
        check_output("wd_err", 32'(bus.m_err_o), 32'h1);
        check_output("wd_cyc_dropped", 32'(bus.s_cyc_o), 32'h0);
        check_output("wd_err_addr", bus.err_addr_o, 32'h2000_0100);
        drop_all();
        tick();
        check_output("wd_timeout_pulse", 32'(bus.timeout_o), 32'h0);
        check_output("wd_err_pulse", 32'(bus.m_err_o), 32'h0);

        // Master abort with stray acks from an unselected and then an idle slave.
        start_req(32'h1000_0008, 1'b0, 32'h0);
        tick();
        check_output("abort_strobe", 32'(bus.s_stb_o), 32'h2);
        bus.s_ack_i[0] = 1'b1;
        #1;
        check_output("unselected_ack_ignored", 32'(bus.m_ack_o), 32'h0);
        bus.s_ack_i = '0;
        tick();
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        #1;
        check_output("abort_cyc", 32'(bus.s_cyc_o), 32'h0);
        check_output("abort_no_ack", 32'(bus.m_ack_o), 32'h0);
        tick();
        bus.s_ack_i[1] = 1'b1;
        #1;
        check_output("stray_ack_idle", 32'(bus.m_ack_o), 32'h0);
        tick();
        check_output("stray_ack_later", 32'(bus.m_ack_o), 32'h0);
        bus.s_ack_i = '0;
        extra = '{32'h1000_0010, 1'b0, 32'h0, 1, 1'b1, 1'b0, 1, 32'h600D_CAFE,
                  5'b00010, 1'b1, 1'b0, 32'h600D_CAFE, 32'h2000_0100};
        apply_stimulus(extra);

        // Reset while a transfer is in flight.
        start_req(32'h0000_0020, 1'b0, 32'h0);
        tick();
        check_output("rst_pre_strobe", 32'(bus.s_stb_o), 32'h1);
        reset_n = 1'b0;
        tick();
        check_output("rst_cyc", 32'(bus.s_cyc_o), 32'h0);
        check_output("rst_ack", 32'(bus.m_ack_o), 32'h0);
        check_output("rst_err", 32'(bus.m_err_o), 32'h0);
        check_output("rst_dat", bus.m_dat_o, 32'h0);
        check_output("rst_err_addr", bus.err_addr_o, 32'h0);
        drop_all();
        reset_n = 1'b1;
        tick();
        extra = '{32'h0000_0030, 1'b0, 32'h0, 0, 1'b1, 1'b0, 2, 32'hFEED_FACE,
                  5'b00001, 1'b1, 1'b0, 32'hFEED_FACE, 32'h0};
        apply_stimulus(extra);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
